// File: rtl/task_2_out_if.sv
// rtl/task_2_out_if.sv - core-side strobe and stream signals of the task 2 output stage
interface task_2_out_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] i_data;
   logic                  i_enb;
   logic                  i_tready;
   logic                  o_tdata_valid;
   logic [DATA_WIDTH-1:0] o_tdata;
   logic                  o_tdata_last;
   logic                  o_output_last;
   logic                  o_overflow;

   modport master (
      input  i_data, i_enb, i_tready,
      output o_tdata_valid, o_tdata, o_tdata_last, o_output_last, o_overflow
   );

   modport slave (
      output i_data, i_enb, i_tready,
      input  o_tdata_valid, o_tdata, o_tdata_last, o_output_last, o_overflow
   );
endinterface

// File: rtl/task_2_out.sv
// rtl/task_2_out.sv - task 2 output stage: two-frame circular buffer feeding a stream master
// TASK_2_OUT_FRAME_GATE_EN selects store-and-forward frame start; default build is cut-through.
module task_2_out #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_WORDS  = 243
) (
   input  logic         i_clk,
   input  logic         i_rst,
   task_2_out_if.master bus
);
   localparam int AW    = $clog2(NUM_WORDS) + 1;
   localparam int DEPTH = 2 ** AW;
   localparam int OW    = AW + 1;
   localparam int CW    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [OW-1:0] DEPTH_OCC = OW'(DEPTH);
   localparam logic [OW-1:0] FRAME_OCC = OW'(NUM_WORDS);
   localparam logic [CW-1:0] LAST_IDX  = CW'(NUM_WORDS - 1);

   typedef enum logic [1:0] {
      s_IDLE = 2'd0,
      s_SEND = 2'd1,
      s_DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [OW-1:0]         occ_q, occ_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  tvalid_q, tvalid_d;
   logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
   logic                  tlast_q, tlast_d;
   logic                  olast_q, olast_d;
   logic                  ovf_q, ovf_d;
   logic                  full;
   logic                  wr_en;
   logic                  hs;
   logic                  load;
   logic                  start;

   // The word parked in the output register still occupies a slot, so total storage is DEPTH.
   assign full  = (occ_q + {{AW{1'b0}}, tvalid_q}) == DEPTH_OCC;
   assign wr_en = bus.i_enb && !full;
   assign hs    = tvalid_q && bus.i_tready;

`ifdef TASK_2_OUT_FRAME_GATE_EN
   assign start = occ_q >= FRAME_OCC;
`else
   assign start = occ_q != '0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= s_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         s_IDLE:  if (start) state_d = s_SEND;
         s_SEND:  if (hs && tlast_q) state_d = s_DONE;
         s_DONE:  state_d = s_IDLE;
         default: state_d = s_IDLE;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == s_IDLE) begin
         cnt_d = '0;
      end else if (hs) begin
         cnt_d = tlast_q ? '0 : cnt_q + 1'b1;
      end

      // Never prefetch past the last word, so the next frame stays fully in the buffer.
      load = (state_q == s_SEND) && (occ_q != '0) && (!tvalid_q || (hs && !tlast_q));

      tvalid_d = tvalid_q;
      tdata_d  = tdata_q;
      tlast_d  = tlast_q;
      if (load) begin
         tvalid_d = 1'b1;
         tdata_d  = mem[rd_ptr_q];
         tlast_d  = (cnt_d == LAST_IDX);
      end else if (hs) begin
         tvalid_d = 1'b0;
         tlast_d  = 1'b0;
      end

      wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, wr_en};
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, load};
      occ_d    = occ_q + {{(OW-1){1'b0}}, wr_en} - {{(OW-1){1'b0}}, load};
      olast_d  = (state_d == s_DONE);
      ovf_d    = ovf_q || (bus.i_enb && full);
   end

   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         mem[wr_ptr_q] <= bus.i_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         cnt_q    <= '0;
         tvalid_q <= 1'b0;
         tdata_q  <= '0;
         tlast_q  <= 1'b0;
         olast_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         cnt_q    <= cnt_d;
         tvalid_q <= tvalid_d;
         tdata_q  <= tdata_d;
         tlast_q  <= tlast_d;
         olast_q  <= olast_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.o_tdata_valid = tvalid_q;
   assign bus.o_tdata       = tdata_q;
   assign bus.o_tdata_last  = tlast_q;
   assign bus.o_output_last = olast_q;
   assign bus.o_overflow    = ovf_q;
endmodule

// File: tb/tb_task_2_out.sv
// tb/tb_task_2_out.sv - self-checking bench for task_2_out with a word scoreboard
module tb_task_2_out;
   localparam int DW    = 8;
   localparam int NW    = 243;
   localparam int DEPTH = 2 ** ($clog2(NW) + 1);

   logic clk = 1'b0;
   logic rst = 1'b1;

   task_2_out_if #(.DATA_WIDTH(DW)) bus ();

   task_2_out #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;
   int first_drive  = 0;
   int last_drive   = 0;
   int ovf_cyc      = -1;
   int stable_err   = 0;

   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] obs_data[$];
   bit            obs_last[$];
   int            rise_q[$];
   int            lasths_q[$];
   int            olast_q[$];

   logic          prev_valid = 1'b0;
   logic          prev_ready = 1'b0;
   logic          prev_last  = 1'b0;
   logic [DW-1:0] prev_data  = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst) begin
         obs_data.delete();
         obs_last.delete();
         rise_q.delete();
         lasths_q.delete();
         olast_q.delete();
         ovf_cyc <= -1;
      end else begin
         if (bus.o_tdata_valid && !prev_valid) rise_q.push_back(cyc);
         if (bus.o_tdata_valid && bus.i_tready) begin
            obs_data.push_back(bus.o_tdata);
            obs_last.push_back(bus.o_tdata_last);
            if (bus.o_tdata_last) lasths_q.push_back(cyc);
         end
         if (bus.o_output_last) olast_q.push_back(cyc);
         if (bus.o_overflow && ovf_cyc < 0) ovf_cyc <= cyc;
         if (prev_valid && !prev_ready &&
             (!bus.o_tdata_valid || bus.o_tdata !== prev_data || bus.o_tdata_last !== prev_last))
            stable_err <= stable_err + 1;
      end
      prev_valid <= bus.o_tdata_valid;
      prev_ready <= bus.i_tready;
      prev_data  <= bus.o_tdata;
      prev_last  <= bus.o_tdata_last;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      bus.i_enb    = 1'b0;
      bus.i_data   = '0;
      bus.i_tready = 1'b0;
      exp_q.delete();
      repeat (3) tick();
      rst = 1'b0;
   endtask

   // rmode: 0 ready high, 1 ready pattern 1,0,0,1, 2 ready low
   task automatic drive(input int n, input int base, input int every, input int rmode,
                        input int olast_target, input int budget, output bit timed_out);
      timed_out = 1'b1;
      for (int k = 0; k < budget; k++) begin
         bit en;
         en = (k % every == 0) && (k / every < n);
         bus.i_enb  = en;
         bus.i_data = DW'(base + k / every);
         if (en) begin
            exp_q.push_back(DW'(base + k / every));
            if (k == 0) first_drive = cyc;
            last_drive = cyc;
         end
         if (rmode == 0)      bus.i_tready = 1'b1;
         else if (rmode == 1) bus.i_tready = (k % 4 == 0) || (k % 4 == 3);
         else                 bus.i_tready = 1'b0;
         tick();
         if (k + 1 >= n * every && olast_q.size() >= olast_target) begin
            timed_out = 1'b0;
            break;
         end
      end
      bus.i_enb = 1'b0;
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      bus.i_enb    = 1'b1;
      bus.i_data   = 8'hA5;
      bus.i_tready = 1'b1;
      repeat (2) tick();
      @(negedge clk);
      tests_run += 5;
      if (bus.o_tdata_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", bus.o_tdata_valid); end
      if (bus.o_tdata !== '0) begin tests_failed++; $display("FAIL reset_tdata: got %h want 00", bus.o_tdata); end
      if (bus.o_tdata_last !== 1'b0) begin tests_failed++; $display("FAIL reset_tlast: got %b want 0", bus.o_tdata_last); end
      if (bus.o_output_last !== 1'b0) begin tests_failed++; $display("FAIL reset_olast: got %b want 0", bus.o_output_last); end
      if (bus.o_overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b want 0", bus.o_overflow); end
   endtask

   task automatic test_basic();
      bit to;
      int exp_rise, got_rise;
      do_reset();
      drive(NW, 0, 1, 0, 1, 2000, to);
      @(negedge clk);
`ifdef TASK_2_OUT_FRAME_GATE_EN
      exp_rise = last_drive + 3;
`else
      exp_rise = first_drive + 3;
`endif
      got_rise = (rise_q.size() > 0) ? rise_q[0] : -1;
      tests_run++;
      if (to !== 1'b0) begin tests_failed++; $display("FAIL basic_timeout: got %0b want 0", to); end
      tests_run++;
      if (got_rise !== exp_rise) begin tests_failed++; $display("FAIL basic_first_valid: got cycle %0d want %0d", got_rise, exp_rise); end
      tests_run++;
      if (rise_q.size() !== 1) begin tests_failed++; $display("FAIL basic_no_bubbles: got %0d valid rises want 1", rise_q.size()); end
      tests_run++;
      if (obs_data.size() !== NW) begin tests_failed++; $display("FAIL basic_count: got %0d words want %0d", obs_data.size(), NW); end
      for (int i = 0; i < NW && i < obs_data.size(); i++) begin
         tests_run++;
         if (obs_data[i] !== exp_q[i] || obs_last[i] !== (i == NW - 1)) begin
            tests_failed++;
            $display("FAIL basic_word[%0d]: got %h last %0b want %h last %0b", i, obs_data[i], obs_last[i], exp_q[i], i == NW - 1);
         end
      end
      tests_run++;
      if (olast_q.size() !== 1) begin tests_failed++; $display("FAIL basic_olast_count: got %0d want 1", olast_q.size()); end
      if (olast_q.size() > 0 && lasths_q.size() > 0) begin
         tests_run++;
         if (olast_q[0] !== lasths_q[0] + 1) begin tests_failed++; $display("FAIL basic_olast_timing: got cycle %0d want %0d", olast_q[0], lasths_q[0] + 1); end
      end
   endtask

   task automatic test_backpressure();
      bit to;
      int base_err;
      do_reset();
      base_err = stable_err;
      drive(NW, 0, 1, 1, 1, 3000, to);
      @(negedge clk);
      tests_run++;
      if (to !== 1'b0) begin tests_failed++; $display("FAIL bp_timeout: got %0b want 0", to); end
      tests_run++;
      if (obs_data.size() !== NW) begin tests_failed++; $display("FAIL bp_count: got %0d words want %0d", obs_data.size(), NW); end
      for (int i = 0; i < NW && i < obs_data.size(); i++) begin
         tests_run++;
         if (obs_data[i] !== exp_q[i] || obs_last[i] !== (i == NW - 1)) begin
            tests_failed++;
            $display("FAIL bp_word[%0d]: got %h last %0b want %h last %0b", i, obs_data[i], obs_last[i], exp_q[i], i == NW - 1);
         end
      end
      tests_run++;
      if (stable_err - base_err !== 0) begin tests_failed++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stable_err - base_err); end
      tests_run++;
      if (olast_q.size() !== 1) begin tests_failed++; $display("FAIL bp_olast_count: got %0d want 1", olast_q.size()); end
   endtask

   task automatic test_overlap();
      bit to;
      int gap;
      do_reset();
      drive(2 * NW, 0, 1, 0, 2, 3000, to);
      @(negedge clk);
      tests_run++;
      if (to !== 1'b0) begin tests_failed++; $display("FAIL ovl_timeout: got %0b want 0", to); end
      tests_run++;
      if (obs_data.size() !== 2 * NW) begin tests_failed++; $display("FAIL ovl_count: got %0d words want %0d", obs_data.size(), 2 * NW); end
      for (int i = 0; i < 2 * NW && i < obs_data.size(); i++) begin
         tests_run++;
         if (obs_data[i] !== exp_q[i] || obs_last[i] !== (i % NW == NW - 1)) begin
            tests_failed++;
            $display("FAIL ovl_word[%0d]: got %h last %0b want %h last %0b", i, obs_data[i], obs_last[i], exp_q[i], i % NW == NW - 1);
         end
      end
      tests_run++;
      if (olast_q.size() !== 2) begin tests_failed++; $display("FAIL ovl_olast_count: got %0d want 2", olast_q.size()); end
      gap = -1;
      if (lasths_q.size() > 0) begin
         foreach (rise_q[i]) if (gap < 0 && rise_q[i] > lasths_q[0]) gap = rise_q[i] - lasths_q[0];
      end
      tests_run++;
      if (gap < 3) begin tests_failed++; $display("FAIL ovl_gap: got %0d cycles from last handshake to next valid want >=3", gap); end
      tests_run++;
      if (bus.o_overflow !== 1'b0) begin tests_failed++; $display("FAIL ovl_overflow: got %b want 0", bus.o_overflow); end
   endtask

   task automatic test_overflow();
      bit to, to2;
      int strobe_cyc;
      do_reset();
      drive(DEPTH + 1, 0, 1, 2, 0, 600, to);
      strobe_cyc = last_drive;
      drive(0, 0, 1, 0, 1, 2000, to2);
      @(negedge clk);
      tests_run++;
      if (to !== 1'b0 || to2 !== 1'b0) begin tests_failed++; $display("FAIL ovf_timeout: got %0b/%0b want 0/0", to, to2); end
      tests_run++;
      if (ovf_cyc !== strobe_cyc + 1) begin tests_failed++; $display("FAIL ovf_set_cycle: got %0d want %0d", ovf_cyc, strobe_cyc + 1); end
      tests_run++;
      if (obs_data.size() < NW) begin tests_failed++; $display("FAIL ovf_count: got %0d words want >=%0d", obs_data.size(), NW); end
      for (int i = 0; i < NW && i < obs_data.size(); i++) begin
         tests_run++;
         if (obs_data[i] !== exp_q[i] || obs_last[i] !== (i == NW - 1)) begin
            tests_failed++;
            $display("FAIL ovf_word[%0d]: got %h last %0b want %h last %0b", i, obs_data[i], obs_last[i], exp_q[i], i == NW - 1);
         end
      end
      tests_run++;
      if (bus.o_overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %b want 1", bus.o_overflow); end
      do_reset();
      @(negedge clk);
      tests_run++;
      if (bus.o_overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear: got %b want 0", bus.o_overflow); end
   endtask

   task automatic test_cut_through();
      bit to;
      int exp_rise, exp_rises, got_rise;
      do_reset();
      drive(NW, 0, 3, 0, 1, 3000, to);
      @(negedge clk);
`ifdef TASK_2_OUT_FRAME_GATE_EN
      exp_rise  = last_drive + 3;
      exp_rises = 1;
`else
      exp_rise  = first_drive + 3;
      exp_rises = NW;
`endif
      got_rise = (rise_q.size() > 0) ? rise_q[0] : -1;
      tests_run++;
      if (to !== 1'b0) begin tests_failed++; $display("FAIL ct_timeout: got %0b want 0", to); end
      tests_run++;
      if (got_rise !== exp_rise) begin tests_failed++; $display("FAIL ct_first_valid: got cycle %0d want %0d", got_rise, exp_rise); end
      tests_run++;
      if (rise_q.size() !== exp_rises) begin tests_failed++; $display("FAIL ct_valid_rises: got %0d want %0d", rise_q.size(), exp_rises); end
      tests_run++;
      if (obs_data.size() !== NW) begin tests_failed++; $display("FAIL ct_count: got %0d words want %0d", obs_data.size(), NW); end
      for (int i = 0; i < NW && i < obs_data.size(); i++) begin
         tests_run++;
         if (obs_data[i] !== exp_q[i] || obs_last[i] !== (i == NW - 1)) begin
            tests_failed++;
            $display("FAIL ct_word[%0d]: got %h last %0b want %h last %0b", i, obs_data[i], obs_last[i], exp_q[i], i == NW - 1);
         end
      end
      tests_run++;
      if (olast_q.size() !== 1) begin tests_failed++; $display("FAIL ct_olast_count: got %0d want 1", olast_q.size()); end
   endtask

   task automatic test_reset_mid_frame();
      bit to;
      bit reached;
      do_reset();
      reached = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         bus.i_enb    = (k < NW);
         bus.i_data   = DW'(k);
         bus.i_tready = 1'b1;
         tick();
         if (obs_data.size() >= 101) begin
            reached = 1'b1;
            break;
         end
      end
      tests_run++;
      if (reached !== 1'b1) begin tests_failed++; $display("FAIL mid_reach: got %0b want 1", reached); end
      tests_run++;
      if (olast_q.size() !== 0) begin tests_failed++; $display("FAIL mid_early_olast: got %0d pulses want 0", olast_q.size()); end
      rst       = 1'b1;
      bus.i_enb = 1'b0;
      tick();
      @(negedge clk);
      tests_run += 5;
      if (bus.o_tdata_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_valid: got %b want 0", bus.o_tdata_valid); end
      if (bus.o_tdata !== '0) begin tests_failed++; $display("FAIL mid_tdata: got %h want 00", bus.o_tdata); end
      if (bus.o_tdata_last !== 1'b0) begin tests_failed++; $display("FAIL mid_tlast: got %b want 0", bus.o_tdata_last); end
      if (bus.o_output_last !== 1'b0) begin tests_failed++; $display("FAIL mid_olast: got %b want 0", bus.o_output_last); end
      if (bus.o_overflow !== 1'b0) begin tests_failed++; $display("FAIL mid_ovf: got %b want 0", bus.o_overflow); end
      #1;
      rst = 1'b0;
      exp_q.delete();
      repeat (10) tick();
      @(negedge clk);
      tests_run++;
      if (olast_q.size() !== 0 || obs_data.size() !== 0) begin
         tests_failed++;
         $display("FAIL mid_after_reset: got %0d pulses %0d words want 0 0", olast_q.size(), obs_data.size());
      end
      drive(NW, 0, 1, 0, 1, 2000, to);
      @(negedge clk);
      tests_run++;
      if (to !== 1'b0) begin tests_failed++; $display("FAIL mid_timeout: got %0b want 0", to); end
      tests_run++;
      if (obs_data.size() !== NW) begin tests_failed++; $display("FAIL mid_count: got %0d words want %0d", obs_data.size(), NW); end
      for (int i = 0; i < NW && i < obs_data.size(); i++) begin
         tests_run++;
         if (obs_data[i] !== exp_q[i] || obs_last[i] !== (i == NW - 1)) begin
            tests_failed++;
            $display("FAIL mid_word[%0d]: got %h last %0b want %h last %0b", i, obs_data[i], obs_last[i], exp_q[i], i == NW - 1);
         end
      end
      tests_run++;
      if (olast_q.size() !== 1) begin tests_failed++; $display("FAIL mid_olast_count: got %0d want 1", olast_q.size()); end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.i_enb    = 1'b0;
      bus.i_data   = '0;
      bus.i_tready = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_overlap();
      test_overflow();
      test_cut_through();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
